// File: rtl/fb_port_scheduler_if.sv
// Writer-side handshake bundle for fb_port_scheduler.
//   master : game-logic pixel writer (drives request, sees ready/oob)
//   slave  : scheduler (sees request, drives ready/oob)
// Signals:
//   wr_valid  writer request
//   wr_ready  port granted to the writer this cycle
//   wr_addr   linear write address, y*FB_W + x
//   wr_data   RRRGGGBB write colour
//   wr_oob    one-cycle pulse after an accepted out-of-range write
interface fb_port_scheduler_if #(
  parameter int ADDR_W = 15
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              wr_oob;

  modport master (output wr_valid, wr_addr, wr_data, input  wr_ready, wr_oob);
  modport slave  (input  wr_valid, wr_addr, wr_data, output wr_ready, wr_oob);
endinterface

// File: rtl/fb_port_scheduler.sv
// Shares one single-port, synchronous-read framebuffer RAM between display
// scan-out (priority) and a game-logic pixel writer. Each stored pixel is
// shown as a (1<<SCALE_SHIFT)-square block, so a display read is only issued
// when scan-out crosses into a new block; every other cycle belongs to the
// writer. Coordinate-to-colour latency is fixed at 2 cycles.
// Ports:
//   clock, reset        pixel clock, synchronous active-high reset
//   i_disp_x/y          display coordinate, 2 cycles ahead of the pixel
//   i_disp_active       coordinate is in the visible region
//   o_color_out         colour for the coordinate presented 2 cycles earlier
//   wr                  writer handshake (slave side)
//   o_ram_addr/we/wdata RAM command
//   i_ram_rdata         RAM read data, 1 cycle after the address
module fb_port_scheduler #(
  parameter int FB_W        = 160,
  parameter int FB_H        = 120,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_W      = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [9:0]        i_disp_x,
  input  logic [9:0]        i_disp_y,
  input  logic              i_disp_active,
  output logic [7:0]        o_color_out,
  fb_port_scheduler_if.slave wr,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  output logic [7:0]        o_ram_wdata,
  input  logic [7:0]        i_ram_rdata
);

  localparam logic [31:0] FB_SIZE = 32'(FB_W * FB_H);

  // S0: block address of the incoming coordinate
  logic [ADDR_W-1:0] w_bx, w_by, w_blk;
  logic              w_fetch;

  logic              r_last_valid;
  logic [ADDR_W-1:0] r_last_blk;

  // Stage bits: index 1 = S1 (port cycle), index 2 = S2 (data return)
  logic [2:1]        r_vld_pipe;
  logic [2:1]        r_fetch_pipe;
  logic [ADDR_W-1:0] r_p1_addr;
  logic [7:0]        r_held;
  logic              r_wr_oob;

  logic              w_wr_ready, w_accept, w_in_range;

  assign w_bx  = ADDR_W'(i_disp_x >> SCALE_SHIFT);
  assign w_by  = ADDR_W'(i_disp_y >> SCALE_SHIFT);
  assign w_blk = w_by * ADDR_W'(FB_W) + w_bx;

  // Clearing last_valid on every inactive cycle forces a fetch at line start,
  // even when the new line maps to the same block as the previous one.
  assign w_fetch = i_disp_active && (!r_last_valid || (w_blk != r_last_blk));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last_valid <= 1'b0;
      r_last_blk   <= '0;
      r_vld_pipe   <= '0;
      r_fetch_pipe <= '0;
      r_p1_addr    <= '0;
      r_held       <= '0;
      r_wr_oob     <= 1'b0;
    end else begin
      r_last_valid <= i_disp_active;
      if (i_disp_active) r_last_blk <= w_blk;
      r_vld_pipe   <= {r_vld_pipe[1],   i_disp_active};
      r_fetch_pipe <= {r_fetch_pipe[1], w_fetch};
      r_p1_addr    <= w_blk;
      if (r_fetch_pipe[2]) r_held <= i_ram_rdata;
      r_wr_oob     <= w_accept && !w_in_range;
    end
  end

  // S1: display fetch owns the port; otherwise the writer does.
  // Out-of-range writes are still handshaked so the writer never wedges.
  assign w_in_range  = 32'(wr.wr_addr) < FB_SIZE;
  assign w_wr_ready  = !reset && !r_fetch_pipe[1];
  assign w_accept    = wr.wr_valid && w_wr_ready;

  assign wr.wr_ready = w_wr_ready;
  assign wr.wr_oob   = r_wr_oob;
  assign o_ram_we    = w_accept && w_in_range;
  assign o_ram_addr  = r_fetch_pipe[1] ? r_p1_addr : wr.wr_addr;
  assign o_ram_wdata = wr.wr_data;

  // S2: fresh RAM data on a fetch cycle, otherwise repeat the held block.
  always_comb begin
    o_color_out = 8'h00;
    if (!reset && r_vld_pipe[2])
      o_color_out = r_fetch_pipe[2] ? i_ram_rdata : r_held;
  end

endmodule
